dp_bit_tcam_lookup: RTL and testbench

Ternary match stage directly downstream of the data-path bit extractor. It consumes the extracted bit vector (`i_dp_bit`, one pulse per packet header) and matches it against a host-configured ternary table of `ENTRY_NUM` entries. It returns the lowest-numbered hitting entry as the parser_table index. It also keeps a saturating miss counter for the control plane.

---
 rtl/dp_bit_tcam_lookup_if.sv | 46 ++++
 rtl/dp_bit_tcam_lookup.sv | 136 +++++++++++++
 tb/tb_dp_bit_tcam_lookup.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_bit_tcam_lookup_if.sv
// Lookup, table-configuration and result signals between the bit extractor / control plane and the ternary match stage.
// Optional macro LKP_DEFAULT_IDX_EN adds the programmable miss-index signals.
interface dp_bit_tcam_lookup_if #(
    parameter int KEY_WIDTH = 128,
    parameter int IDX_WIDTH = 4
);
    logic [KEY_WIDTH-1:0] i_dp_bit;
    logic                 i_dp_bit_valid;
    logic [KEY_WIDTH-1:0] i_dp_bit_mask;

    logic                 i_cfg_wr_en;
    logic [IDX_WIDTH-1:0] i_cfg_wr_addr;
    logic [KEY_WIDTH-1:0] i_cfg_key;
    logic [KEY_WIDTH-1:0] i_cfg_care;
    logic                 i_cfg_entry_valid;
    logic                 i_cfg_clear;
`ifdef LKP_DEFAULT_IDX_EN
    logic                 i_cfg_default_wr;
    logic [IDX_WIDTH-1:0] i_cfg_default_idx;
`endif

    logic [IDX_WIDTH-1:0] o_lkp_idx;
    logic                 o_lkp_hit;
    logic                 o_lkp_valid;
    logic [15:0]          o_miss_cnt;

    modport master (
`ifdef LKP_DEFAULT_IDX_EN
        output i_cfg_default_wr, i_cfg_default_idx,
`endif
        output i_dp_bit, i_dp_bit_valid, i_dp_bit_mask,
        output i_cfg_wr_en, i_cfg_wr_addr, i_cfg_key, i_cfg_care,
        output i_cfg_entry_valid, i_cfg_clear,
        input  o_lkp_idx, o_lkp_hit, o_lkp_valid, o_miss_cnt
    );

    modport slave (
`ifdef LKP_DEFAULT_IDX_EN
        input  i_cfg_default_wr, i_cfg_default_idx,
`endif
        input  i_dp_bit, i_dp_bit_valid, i_dp_bit_mask,
        input  i_cfg_wr_en, i_cfg_wr_addr, i_cfg_key, i_cfg_care,
        input  i_cfg_entry_valid, i_cfg_clear,
        output o_lkp_idx, o_lkp_hit, o_lkp_valid, o_miss_cnt
    );
endinterface

// File: rtl/dp_bit_tcam_lookup.sv
// Three-stage register-based ternary match of the extracted bit vector; returns lowest hitting entry and counts misses.
// Optional macro LKP_DEFAULT_IDX_EN: programmable index reported on a miss (otherwise 0).
module dp_bit_tcam_lookup #(
    parameter int KEY_WIDTH = 128,
    parameter int ENTRY_NUM = 16,
    parameter int IDX_WIDTH = 4
) (
    input  logic                  axis_clk,
    input  logic                  aresetn,
    dp_bit_tcam_lookup_if.slave   bus
);
    localparam logic [IDX_WIDTH:0] ENTRY_LIM = (IDX_WIDTH+1)'(ENTRY_NUM);

    logic [KEY_WIDTH-1:0] tbl_key  [ENTRY_NUM];
    logic [KEY_WIDTH-1:0] tbl_care [ENTRY_NUM];
    logic [ENTRY_NUM-1:0] tbl_valid;

    logic [KEY_WIDTH-1:0] s1_key;
    logic                 s1_valid;
    logic [ENTRY_NUM-1:0] hit_vec;
    logic [ENTRY_NUM-1:0] s2_hit;
    logic                 s2_valid;

    logic [IDX_WIDTH-1:0] enc_idx;
    logic                 enc_any;
    logic [IDX_WIDTH-1:0] miss_idx;

    logic [IDX_WIDTH-1:0] lkp_idx;
    logic                 lkp_hit;
    logic                 lkp_valid;
    logic [15:0]          miss_cnt;

    logic                 wr_in_range;

    assign wr_in_range = ({1'b0, bus.i_cfg_wr_addr} < ENTRY_LIM);

    // Clear takes priority over a same-cycle write, which is then dropped.
    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            tbl_valid <= '0;
            for (int e = 0; e < ENTRY_NUM; e++) begin
                tbl_key[e]  <= '0;
                tbl_care[e] <= '0;
            end
        end else if (bus.i_cfg_clear) begin
            tbl_valid <= '0;
        end else if (bus.i_cfg_wr_en && wr_in_range) begin
            tbl_key[bus.i_cfg_wr_addr]   <= bus.i_cfg_key;
            tbl_care[bus.i_cfg_wr_addr]  <= bus.i_cfg_care;
            tbl_valid[bus.i_cfg_wr_addr] <= bus.i_cfg_entry_valid;
        end
    end

`ifdef LKP_DEFAULT_IDX_EN
    logic [IDX_WIDTH-1:0] default_idx;

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            default_idx <= '0;
        end else if (bus.i_cfg_default_wr) begin
            default_idx <= bus.i_cfg_default_idx;
        end
    end

    assign miss_idx = default_idx;
`else
    assign miss_idx = '0;
`endif

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            s1_key   <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= bus.i_dp_bit_valid;
            if (bus.i_dp_bit_valid) begin
                s1_key <= bus.i_dp_bit & bus.i_dp_bit_mask;
            end
        end
    end

    // Compare against the live table so a write in the lookup's input cycle is already visible here.
    always_comb begin
        hit_vec = '0;
        for (int e = 0; e < ENTRY_NUM; e++) begin
            hit_vec[e] = tbl_valid[e] && (((s1_key ^ tbl_key[e]) & tbl_care[e]) == '0);
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            s2_hit   <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_hit <= hit_vec;
            end
        end
    end

    // Scan from the top so the lowest set index is the last assignment.
    always_comb begin
        enc_idx = '0;
        enc_any = |s2_hit;
        for (int e = ENTRY_NUM - 1; e >= 0; e--) begin
            if (s2_hit[e]) begin
                enc_idx = IDX_WIDTH'(e);
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            lkp_idx   <= '0;
            lkp_hit   <= 1'b0;
            lkp_valid <= 1'b0;
            miss_cnt  <= '0;
        end else begin
            lkp_valid <= s2_valid;
            if (s2_valid) begin
                lkp_idx <= enc_any ? enc_idx : miss_idx;
                lkp_hit <= enc_any;
                if (!enc_any && (miss_cnt != 16'hFFFF)) begin
                    miss_cnt <= miss_cnt + 16'd1;
                end
            end
        end
    end

    assign bus.o_lkp_idx   = lkp_idx;
    assign bus.o_lkp_hit   = lkp_hit;
    assign bus.o_lkp_valid = lkp_valid;
    assign bus.o_miss_cnt  = miss_cnt;

endmodule

// File: tb/tb_dp_bit_tcam_lookup.sv
// Directed scoreboard bench for dp_bit_tcam_lookup; expected results queued at drive time, checked when o_lkp_valid pulses.
// Define LKP_DEFAULT_IDX_EN for both bench and RTL to cover the default miss index.
module tb_dp_bit_tcam_lookup;
   localparam int KW = 128;
   localparam int EN = 16;
   localparam int IW = 4;

   typedef struct {
      logic          hit;
      logic [IW-1:0] idx;
      logic [15:0]   cnt;
      int            due;
   } exp_t;

   logic clk = 1'b0;
   logic aresetn = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 1'b0;

   exp_t          q[$];
   exp_t          mon_e;
   logic [IW-1:0] last_idx = '0;
   logic          last_hit = 1'b0;
   logic [15:0]   model_cnt = '0;
   logic [IW-1:0] exp_miss_idx = '0;

   dp_bit_tcam_lookup_if #(.KEY_WIDTH(KW), .IDX_WIDTH(IW)) bus ();

   dp_bit_tcam_lookup #(.KEY_WIDTH(KW), .ENTRY_NUM(EN), .IDX_WIDTH(IW)) dut (
      .axis_clk (clk),
      .aresetn  (aresetn),
      .bus      (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.o_lkp_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $error("FAIL unexpected_valid observed=%0d expected=nonzero", q.size());
            end
            if (q.size() != 0) begin
               mon_e = q.pop_front();
               checks++;
               if (bus.o_lkp_hit !== mon_e.hit) begin
                  failures++;
                  $error("FAIL hit observed=%0h expected=%0h", bus.o_lkp_hit, mon_e.hit);
               end
               checks++;
               if (bus.o_lkp_idx !== mon_e.idx) begin
                  failures++;
                  $error("FAIL idx observed=%0h expected=%0h", bus.o_lkp_idx, mon_e.idx);
               end
               checks++;
               if (bus.o_miss_cnt !== mon_e.cnt) begin
                  failures++;
                  $error("FAIL miss_cnt observed=%0h expected=%0h", bus.o_miss_cnt, mon_e.cnt);
               end
               checks++;
               if (cyc != mon_e.due) begin
                  failures++;
                  $error("FAIL latency observed=%0d expected=%0d", cyc, mon_e.due);
               end
               last_idx = mon_e.idx;
               last_hit = mon_e.hit;
            end
         end else begin
            checks++;
            if (bus.o_lkp_idx !== last_idx) begin
               failures++;
               $error("FAIL hold_idx observed=%0h expected=%0h", bus.o_lkp_idx, last_idx);
            end
            checks++;
            if (bus.o_lkp_hit !== last_hit) begin
               failures++;
               $error("FAIL hold_hit observed=%0h expected=%0h", bus.o_lkp_hit, last_hit);
            end
         end
      end
   end

   task automatic clear_strobes();
      bus.i_dp_bit_valid = 1'b0;
      bus.i_cfg_wr_en    = 1'b0;
      bus.i_cfg_clear    = 1'b0;
`ifdef LKP_DEFAULT_IDX_EN
      bus.i_cfg_default_wr = 1'b0;
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      clear_strobes();
   endtask

   task automatic set_lookup(input logic [KW-1:0] key, input logic [KW-1:0] mask,
                             input logic hit, input logic [IW-1:0] idx);
      exp_t e;
      bus.i_dp_bit       = key;
      bus.i_dp_bit_mask  = mask;
      bus.i_dp_bit_valid = 1'b1;
      if (!hit && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
      e.hit = hit;
      e.idx = hit ? idx : exp_miss_idx;
      e.cnt = model_cnt;
      e.due = cyc + 3;
      q.push_back(e);
   endtask

   task automatic set_write(input logic [IW-1:0] addr, input logic [KW-1:0] key,
                            input logic [KW-1:0] care, input logic v);
      bus.i_cfg_wr_en       = 1'b1;
      bus.i_cfg_wr_addr     = addr;
      bus.i_cfg_key         = key;
      bus.i_cfg_care        = care;
      bus.i_cfg_entry_valid = v;
   endtask

   task automatic do_clear();
      bus.i_cfg_clear = 1'b1;
      tick();
   endtask

   task automatic do_reset();
      mon_en  = 1'b0;
      aresetn = 1'b0;
      clear_strobes();
      repeat (3) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.o_lkp_valid !== 1'b0) begin
            failures++;
            $error("FAIL rst_valid observed=%0h expected=0", bus.o_lkp_valid);
         end
         checks++;
         if (bus.o_lkp_hit !== 1'b0) begin
            failures++;
            $error("FAIL rst_hit observed=%0h expected=0", bus.o_lkp_hit);
         end
         checks++;
         if (bus.o_lkp_idx !== 4'd0) begin
            failures++;
            $error("FAIL rst_idx observed=%0h expected=0", bus.o_lkp_idx);
         end
         checks++;
         if (bus.o_miss_cnt !== 16'd0) begin
            failures++;
            $error("FAIL rst_miss_cnt observed=%0h expected=0", bus.o_miss_cnt);
         end
      end
      aresetn = 1'b1;
      q.delete();
      last_idx     = '0;
      last_hit     = 1'b0;
      model_cnt    = '0;
      exp_miss_idx = '0;
      mon_en       = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() != 0; i++) tick();
      checks++;
      if (q.size() != 0) begin
         failures++;
         $error("FAIL drain_timeout observed=%0d expected=0", q.size());
      end
      repeat (3) tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_dp_bit          = '0;
      bus.i_dp_bit_mask     = '0;
      bus.i_cfg_wr_addr     = '0;
      bus.i_cfg_key         = '0;
      bus.i_cfg_care        = '0;
      bus.i_cfg_entry_valid = 1'b0;
`ifdef LKP_DEFAULT_IDX_EN
      bus.i_cfg_default_idx = '0;
`endif
      clear_strobes();
      do_reset();

      // Empty table misses
      set_lookup(128'h1, '1, 1'b0, 4'd0); tick();
      drain();

      // Lowest index wins; all-zero care matches anything
      set_write(4'd3, 128'hA5, 128'hFF, 1'b1); tick();
      set_write(4'd7, 128'hA5, 128'h0, 1'b1); tick();
      set_lookup({120'h0123_4567_89AB_CDEF_0011_2233_4455_66, 8'hA5}, '1, 1'b1, 4'd3); tick();
      set_write(4'd3, 128'hA5, 128'hFF, 1'b0); tick();
      set_lookup({120'h0123_4567_89AB_CDEF_0011_2233_4455_66, 8'hA5}, '1, 1'b1, 4'd7); tick();
      drain();

      // Extraction mask zeroes unextracted key bits
      do_clear();
      set_write(4'd2, 128'hF0, 128'hF0, 1'b1); tick();
      set_lookup(128'hFF, 128'hF0, 1'b1, 4'd2); tick();
      set_lookup(128'hFF, 128'h0F, 1'b0, 4'd0); tick();
      drain();

      // Table coherency around the compare cycle
      do_clear();
      set_write(4'd5, 128'h55, '1, 1'b1);
      set_lookup(128'h55, '1, 1'b1, 4'd5); tick();
      do_clear();
      set_lookup(128'h66, '1, 1'b0, 4'd0); tick();
      set_write(4'd5, 128'h66, '1, 1'b1); tick();
      set_lookup(128'h66, '1, 1'b1, 4'd5); tick();
      bus.i_cfg_clear = 1'b1;
      set_write(4'd5, 128'h77, '1, 1'b1); tick();
      set_lookup(128'h77, '1, 1'b0, 4'd0); tick();
      drain();

      // Back-to-back alternating hit/miss
      set_write(4'd1, 128'h11, '1, 1'b1); tick();
      set_lookup(128'h11, '1, 1'b1, 4'd1); tick();
      set_lookup(128'h22, '1, 1'b0, 4'd0); tick();
      set_lookup(128'h11, '1, 1'b1, 4'd1); tick();
      set_lookup(128'h22, '1, 1'b0, 4'd0); tick();
      drain();

`ifdef LKP_DEFAULT_IDX_EN
      bus.i_cfg_default_wr  = 1'b1;
      bus.i_cfg_default_idx = 4'd9;
      exp_miss_idx          = 4'd9;
      tick();
      set_lookup(128'h33, '1, 1'b0, 4'd0); tick();
      set_lookup(128'h11, '1, 1'b1, 4'd1); tick();
      drain();
`endif

      // Reset with a lookup in flight: no result may emerge
      bus.i_dp_bit       = 128'h11;
      bus.i_dp_bit_mask  = '1;
      bus.i_dp_bit_valid = 1'b1;
      tick();
      do_reset();
      repeat (6) tick();

      // Miss counter saturation
      for (int i = 0; i < 32'hFFFE; i++) begin
         set_lookup(128'h5A, '1, 1'b0, 4'd0); tick();
      end
      drain();
      checks++;
      if (bus.o_miss_cnt !== 16'hFFFE) begin
         failures++;
         $error("FAIL miss_cnt_fffe observed=%0h expected=fffe", bus.o_miss_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         set_lookup(128'h5A, '1, 1'b0, 4'd0); tick();
      end
      drain();
      checks++;
      if (bus.o_miss_cnt !== 16'hFFFF) begin
         failures++;
         $error("FAIL miss_cnt_sat observed=%0h expected=ffff", bus.o_miss_cnt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
